// File: rtl/roach_reset_sequencer.sv
// Start-up sequencer for the sys_clk domain: waits for a stable clock lock, pulses the
// IDELAYCTRL reset, waits for ready (with retries), then releases the user-logic reset.
module roach_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned IDELAY_RST_CYCLES  = 16,
  parameter int unsigned RDY_TIMEOUT        = 4096,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       op_power_on_rst,
  input  logic       sys_clk_lock,
  input  logic       idelay_rdy,
  output logic       idelay_rst,
  output logic       sys_rst_out,
  output logic       seq_done,
  output logic       seq_fail,
  output logic [1:0] retry_count,
  output logic [2:0] seq_state
);

  // state       | meaning
  // WAIT_LOCK   | waiting for sys_clk_lock
  // LOCK_STABLE | counting consecutive locked cycles
  // IDLY_RST    | driving idelay_rst
  // WAIT_RDY    | waiting for synchronized idelay_rdy, timeout -> retry or FAIL
  // RUN         | user reset released
  // FAIL        | retries exhausted, sticky until rst/op_power_on_rst
  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    IDLY_RST    = 3'd2,
    WAIT_RDY    = 3'd3,
    RUN         = 3'd4,
    FAIL        = 3'd5
  } state_t;

  localparam logic [15:0] LOCK_LAST    = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] IDLY_LAST    = 16'(IDELAY_RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(RDY_TIMEOUT - 1);
  localparam logic [15:0] BLANK_CYCLES = 16'd4;
  localparam logic [1:0]  RETRY_MAX    = 2'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  retry_q, retry_d;
  logic        rdy_meta, rdy_s;
  logic        seq_reset;

  assign seq_reset = rst | op_power_on_rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      WAIT_LOCK: begin
        if (sys_clk_lock) state_d = LOCK_STABLE;
      end
      LOCK_STABLE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LOCK_LAST) state_d = IDLY_RST;
      end
      IDLY_RST: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == IDLY_LAST) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        cnt_d = cnt_q + 16'd1;
        // ready wins over a coinciding timeout; early ready may be stale from a prior attempt
        if (rdy_s && (cnt_q >= BLANK_CYCLES)) begin
          state_d = RUN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = IDLY_RST;
          end else begin
            state_d = FAIL;
          end
        end
      end
      RUN: begin
        if (!rdy_s) state_d = IDLY_RST;
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    if (!sys_clk_lock && (state_q inside {LOCK_STABLE, IDLY_RST, WAIT_RDY, RUN})) begin
      state_d = WAIT_LOCK;
      retry_d = retry_q;
    end

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (seq_reset) begin
      rdy_meta    <= 1'b0;
      rdy_s       <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      retry_q     <= '0;
      idelay_rst  <= 1'b0;
      sys_rst_out <= 1'b1;
      seq_done    <= 1'b0;
      seq_fail    <= 1'b0;
    end else begin
      rdy_meta    <= idelay_rdy;
      rdy_s       <= rdy_meta;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      idelay_rst  <= (state_d == IDLY_RST);
      sys_rst_out <= (state_d != RUN);
      seq_done    <= (state_d == RUN);
      seq_fail    <= (state_d == FAIL);
    end
  end

  assign retry_count = retry_q;
  assign seq_state   = state_q;

endmodule
